spi_frame_sequencer: RTL and testbench

SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

---
 rtl/spi_seq_pkg.sv | 85 ++++++++
 rtl/spi_bit_cnt.sv | 29 ++
 rtl/spi_frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types for spi_frame_sequencer: FSM states, opcodes, the strobe bundle
// and the debug view. Burst behaviour is selected in the top by SPI_SEQ_BURST_EN.
package spi_seq_pkg;

  localparam int BYTE_BITS = 8;
  localparam int CNT_W     = $clog2(BYTE_BITS);

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CMD   = 4'd1,
    ADDR  = 4'd2,
    WDATA = 4'd3,
    WRITE = 4'd4,
    RD    = 4'd5,
    LDTX  = 4'd6,
    TXSH  = 4'd7,
    HOLD  = 4'd8
  } state_t;

  typedef struct packed {
    logic load_cbuf;
    logic latch_a;
    logic dec_a;
    logic rst_a;
    logic latch_rx;
    logic dec_rx;
    logic rst_rx;
    logic load_tx;
    logic shift_tx;
    logic dec_tx;
    logic rst_tx;
    logic re;
    logic we;
  } strobes_t;

  typedef struct packed {
    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
  } dbg_t;

  // Strobe pattern held for the whole time the FSM sits in state s.
  function automatic strobes_t state_strobes(input state_t s);
    strobes_t st;
    st = '0;
    case (s)
      IDLE: begin
        st.rst_a  = 1'b1;
        st.rst_rx = 1'b1;
        st.rst_tx = 1'b1;
      end
      CMD:   st.load_cbuf = 1'b1;
      ADDR: begin
        st.latch_a = 1'b1;
        st.dec_a   = 1'b1;
      end
      WDATA: begin
        st.latch_rx = 1'b1;
        st.dec_rx   = 1'b1;
      end
      WRITE: begin
        st.we     = 1'b1;
        st.rst_rx = 1'b1;
      end
      RD:    st.re = 1'b1;
      LDTX: begin
        st.load_tx = 1'b1;
        st.rst_tx  = 1'b1;
      end
      TXSH: begin
        st.shift_tx = 1'b1;
        st.dec_tx   = 1'b1;
      end
      default: st = '0;
    endcase
    return st;
  endfunction

  function automatic logic is_byte_phase(input state_t s);
    return (s == CMD) || (s == ADDR) || (s == WDATA) || (s == TXSH);
  endfunction

endpackage

// File: rtl/spi_bit_cnt.sv
// Down-counter that times one byte phase: load to BYTE_BITS-1, decrement per sck,
// terminal count when it reaches zero.
module spi_bit_cnt
  import spi_seq_pkg::*;
(
  input  logic             sck,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge sck) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(BYTE_BITS - 1);
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/spi_frame_sequencer.sv
// SPI slave frame sequencer: CMD/ADDR/data byte phases driving SRAM strobes.
// Define SPI_SEQ_BURST_EN to keep streaming bytes with address increment until ss_n rises.
module spi_frame_sequencer
  import spi_seq_pkg::*;
(
  input  logic       sck,
  input  logic       rst,
  input  logic       ss_n,
  input  logic [7:0] cmd,
  output logic       load_cbuf,
  output logic       latch_a,
  output logic       dec_a,
  output logic       rst_a,
  output logic       latch_rx,
  output logic       dec_rx,
  output logic       rst_rx,
  output logic       load_tx,
  output logic       shift_tx,
  output logic       dec_tx,
  output logic       rst_tx,
  output logic       re,
  output logic       we,
  output logic       addr_inc,
  output logic       busy,
  output logic       bad_cmd,
  output dbg_t       o_dbg
);

  state_t           r_state;
  state_t           w_nxt;
  strobes_t         r_stb;
  logic             r_busy;
  logic             r_bad_cmd;
  logic             w_set_bad;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_in_byte;
  logic             w_cnt_load;
  logic             w_cnt_dec;

  // Counter reloads whenever we are outside a byte phase or finishing one,
  // so every phase starts at BYTE_BITS-1 without explicit entry logic.
  assign w_in_byte  = is_byte_phase(r_state);
  assign w_cnt_dec  = w_in_byte && !w_tc;
  assign w_cnt_load = !w_cnt_dec;

  spi_bit_cnt u_bit_cnt (
    .sck    (sck),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_nxt     = r_state;
    w_set_bad = 1'b0;
    if (r_state != IDLE && ss_n) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (!ss_n) w_nxt = CMD;
        CMD:   if (w_tc) w_nxt = ADDR;
        ADDR: begin
          if (w_tc) begin
            if (cmd == OP_WRITE) begin
              w_nxt = WDATA;
            end else if (cmd == OP_READ) begin
              w_nxt = RD;
            end else begin
              w_nxt     = HOLD;
              w_set_bad = 1'b1;
            end
          end
        end
        WDATA: if (w_tc) w_nxt = WRITE;
`ifdef SPI_SEQ_BURST_EN
        WRITE: w_nxt = WDATA;
`else
        WRITE: w_nxt = HOLD;
`endif
        RD:    w_nxt = LDTX;
        LDTX:  w_nxt = TXSH;
`ifdef SPI_SEQ_BURST_EN
        TXSH:  if (w_tc) w_nxt = RD;
`else
        TXSH:  if (w_tc) w_nxt = HOLD;
`endif
        HOLD:  w_nxt = HOLD;
        default: w_nxt = IDLE;
      endcase
    end
  end

`ifdef SPI_SEQ_BURST_EN
  logic r_addr_inc;
  logic w_inc_nxt;

  // Pulse alongside WRITE, and on the final TXSH bit (count 1 now -> 0 next).
  assign w_inc_nxt = (w_nxt == WRITE) ||
                     ((r_state == TXSH) && (w_nxt == TXSH) && (w_cnt == CNT_W'(1)));

  always_ff @(posedge sck) begin
    if (!rst) begin
      r_addr_inc <= 1'b0;
    end else begin
      r_addr_inc <= w_inc_nxt;
    end
  end

  assign addr_inc = r_addr_inc;
`else
  assign addr_inc = 1'b0;
`endif

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge sck) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_stb     <= state_strobes(IDLE);
      r_busy    <= 1'b0;
      r_bad_cmd <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_stb   <= state_strobes(w_nxt);
      r_busy  <= (w_nxt != IDLE);
      if (r_state == IDLE && w_nxt == CMD) begin
        r_bad_cmd <= 1'b0;
      end else if (w_set_bad) begin
        r_bad_cmd <= 1'b1;
      end
    end
  end

  assign load_cbuf     = r_stb.load_cbuf;
  assign latch_a       = r_stb.latch_a;
  assign dec_a         = r_stb.dec_a;
  assign rst_a         = r_stb.rst_a;
  assign latch_rx      = r_stb.latch_rx;
  assign dec_rx        = r_stb.dec_rx;
  assign rst_rx        = r_stb.rst_rx;
  assign load_tx       = r_stb.load_tx;
  assign shift_tx      = r_stb.shift_tx;
  assign dec_tx        = r_stb.dec_tx;
  assign rst_tx        = r_stb.rst_tx;
  assign re            = r_stb.re;
  assign we            = r_stb.we;
  assign busy          = r_busy;
  assign bad_cmd       = r_bad_cmd;
  assign o_dbg.state   = r_state;
  assign o_dbg.bit_cnt = w_cnt;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: per-frame cycle traces plus an SRAM-access
// scoreboard fed by a bench-side address/RX-byte model. Offset k = k-th cycle after CMD entry (entry = 0).
module tb_spi_frame_sequencer;
  import spi_seq_pkg::*;

  logic       sck;
  logic       rst;
  logic       ss_n;
  logic [7:0] cmd;
  logic       sdi;
  logic       load_cbuf, latch_a, dec_a, rst_a, latch_rx, dec_rx, rst_rx;
  logic       load_tx, shift_tx, dec_tx, rst_tx, re, we, addr_inc, busy, bad_cmd;
  dbg_t       dbg;

  spi_frame_sequencer dut (
    .sck(sck), .rst(rst), .ss_n(ss_n), .cmd(cmd),
    .load_cbuf(load_cbuf), .latch_a(latch_a), .dec_a(dec_a), .rst_a(rst_a),
    .latch_rx(latch_rx), .dec_rx(dec_rx), .rst_rx(rst_rx),
    .load_tx(load_tx), .shift_tx(shift_tx), .dec_tx(dec_tx), .rst_tx(rst_tx),
    .re(re), .we(we), .addr_inc(addr_inc), .busy(busy), .bad_cmd(bad_cmd),
    .o_dbg(dbg)
  );

  // bit: 13 addr_inc, 12 we, 11 re, 10 rst_tx, 9 dec_tx, 8 shift_tx, 7 load_tx,
  //      6 rst_rx, 5 dec_rx, 4 latch_rx, 3 rst_a, 2 dec_a, 1 latch_a, 0 load_cbuf
  wire [13:0] stb = {addr_inc, we, re, rst_tx, dec_tx, shift_tx, load_tx,
                     rst_rx, dec_rx, latch_rx, rst_a, dec_a, latch_a, load_cbuf};

  localparam logic [13:0] V_IDLE  = 14'h0448;
  localparam logic [13:0] V_CMD   = 14'h0001;
  localparam logic [13:0] V_ADDR  = 14'h0006;
  localparam logic [13:0] V_WDATA = 14'h0030;
  localparam logic [13:0] V_LDTX  = 14'h0480;
`ifdef SPI_SEQ_BURST_EN
  localparam logic [13:0] V_WRITE = 14'h3040;
  localparam logic [13:0] V_TXEND = 14'h2300;
  localparam state_t      S_AFTER_WR = WDATA;
  localparam state_t      S_AFTER_RD = RD;
  localparam int          N_INC_WR   = 1;
`else
  localparam logic [13:0] V_WRITE = 14'h1040;
  localparam logic [13:0] V_TXEND = 14'h0300;
  localparam state_t      S_AFTER_WR = HOLD;
  localparam state_t      S_AFTER_RD = HOLD;
  localparam int          N_INC_WR   = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0]      trace  [64];
  state_t           st_tr  [64];
  logic [CNT_W-1:0] cnt_tr [64];
  logic             busy_tr[64];
  logic             bad_tr [64];
  logic [13:0]      pre_stb;

  // Scoreboard entries: {is_write, addr, data}; reads carry data 0.
  logic [16:0] exp_q[$];
  logic [7:0]  addr_m;
  logic [7:0]  rx_m;

  // ---------------- clock ----------------
  initial sck = 1'b0;
  always #5 sck = ~sck;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- SRAM-side model + scoreboard ----------------
  always @(negedge sck) begin
    if (re || we) begin
      check("sb_re_we_excl", {31'd0, re & we}, 32'd0);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_access", {15'd0, we, re, 7'd0, addr_m}, 32'd0);
      end else begin
        check("sb_access", {15'd0, we, addr_m, (we ? rx_m : 8'h00)}, {15'd0, exp_q.pop_front()});
      end
    end
    if (latch_a)  addr_m = {addr_m[6:0], sdi};
    if (latch_rx) rx_m   = {rx_m[6:0], sdi};
    if (addr_inc) addr_m = addr_m + 8'd1;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  // Master serial data: address MSB-first at offsets 8..15, then data bytes of
  // 8 bits each separated by the one-cycle WRITE gap.
  function automatic logic sdi_bit(input int k, input logic [7:0] a, input logic [23:0] d);
    int j;
    int b;
    if (k >= 8 && k < 16) return a[15 - k];
    if (k >= 16) begin
      j = (k - 16) / 9;
      b = (k - 16) % 9;
      if (j < 3 && b < 8) return d[23 - 8*j - b];
    end
    return 1'b0;
  endfunction

  task automatic frame(input logic [7:0] op, input logic [7:0] a, input logic [23:0] d,
                       input int n_cyc, input int abort_at, input int rst_at);
    pre_stb = stb;
    ss_n = 1'b0;
    cmd  = 8'h00;
    tick();
    for (int k = 0; k < n_cyc; k++) begin
      sdi = sdi_bit(k, a, d);
      if (k >= 8) cmd = op;
      trace[k]   = stb;
      st_tr[k]   = dbg.state;
      cnt_tr[k]  = dbg.bit_cnt;
      busy_tr[k] = busy;
      bad_tr[k]  = bad_cmd;
      if (k == abort_at) ss_n = 1'b1;
      if (k == rst_at) rst = 1'b0;
      if (rst_at >= 0 && k == rst_at + 2) rst = 1'b1;
      tick();
    end
    ss_n = 1'b1;
    sdi  = 1'b0;
    tick();
    tick();
  endtask

  function automatic int count_bit(input int b, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (trace[k][b]) n++;
    return n;
  endfunction

  function automatic int first_bit(input int b, input int hi);
    for (int k = 0; k <= hi; k++) if (trace[k][b]) return k;
    return -1;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; ss_n = 1'b1; cmd = 8'h00; sdi = 1'b0;
    addr_m = 8'h00; rx_m = 8'h00;

    // Reset, with ss_n low on one reset edge to show reset wins.
    tick();
    ss_n = 1'b0;
    tick();
    ss_n = 1'b1;
    tick();
    check("rst_strobes", stb, V_IDLE);
    check("rst_busy", busy, 0);
    check("rst_bad_cmd", bad_cmd, 0);
    check("rst_state", dbg.state, IDLE);
    check("rst_bit_cnt", dbg.bit_cnt, 0);
    rst = 1'b1;
    tick();
    check("idle_cnt_loaded", dbg.bit_cnt, 7);

    // Write frame: 0x02 @0x10 data 0xA5.
    exp_q.push_back({1'b1, 8'h10, 8'hA5});
    frame(OP_WRITE, 8'h10, 24'hA50000, 28, -1, -1);
    check("wr_idle_rst_strobes", pre_stb, V_IDLE);
    check("wr_cmd_first", trace[0], V_CMD);
    check("wr_cmd_last", trace[7], V_CMD);
    check("wr_addr_first", trace[8], V_ADDR);
    check("wr_wdata_first", trace[16], V_WDATA);
    check("wr_wdata_cnt7", cnt_tr[16], 7);
    check("wr_wdata_last", trace[23], V_WDATA);
    check("wr_we_offset", first_bit(12, 27), 24);
    check("wr_we_count", count_bit(12, 0, 27), 1);
    check("wr_write_vec", trace[24], V_WRITE);
    check("wr_addr_inc_count", count_bit(13, 0, 27), N_INC_WR);
    check("wr_next_state", st_tr[25], S_AFTER_WR);
    check("wr_busy", busy_tr[25], 1);
    check("wr_end_idle", stb, V_IDLE);
    check("wr_end_busy", busy, 0);
    check("wr_sb_drained", exp_q.size(), 0);

    // Read frame: 0x03 @0x20. re at offset 16 (cycle 17 counting entry as 1), load_tx at 17.
    exp_q.push_back({1'b0, 8'h20, 8'h00});
`ifdef SPI_SEQ_BURST_EN
    exp_q.push_back({1'b0, 8'h21, 8'h00});
`endif
    frame(OP_READ, 8'h20, 24'h000000, 28, -1, -1);
    check("rd_re_offset", first_bit(11, 27), 16);
    check("rd_re_count", count_bit(11, 0, 25), 1);
    check("rd_ldtx_vec", trace[17], V_LDTX);
    check("rd_shift_first", first_bit(8, 27), 18);
    check("rd_shift_count", count_bit(8, 0, 25), 8);
    check("rd_txsh_last", trace[25], V_TXEND);
    check("rd_next_state", st_tr[26], S_AFTER_RD);
    check("rd_no_we", count_bit(12, 0, 27), 0);
    check("rd_sb_drained", exp_q.size(), 0);

    // Bad opcode 0x7F.
    frame(8'h7F, 8'h33, 24'h000000, 22, -1, -1);
    check("bad_flag_before", bad_tr[15], 0);
    check("bad_flag_set", bad_tr[16], 1);
    check("bad_hold", st_tr[16], HOLD);
    check("bad_hold_quiet", trace[20], 14'h0000);
    check("bad_no_access", count_bit(11, 0, 21) + count_bit(12, 0, 21), 0);
    check("bad_sticky_idle", bad_cmd, 1);

    // Abort: ss_n raised at WDATA bit 5 (offset 21).
    frame(OP_WRITE, 8'h44, 24'h5A0000, 26, 21, -1);
    check("abort_bad_cleared", bad_tr[0], 0);
    check("abort_cnt_bit5", cnt_tr[21], 2);
    check("abort_idle_vec", trace[22], V_IDLE);
    check("abort_state", st_tr[22], IDLE);
    check("abort_busy", busy_tr[22], 0);
    check("abort_no_we", count_bit(12, 0, 25), 0);

    // Reset mid-TXSH (offset 20), held two edges, then ss_n still low restarts CMD.
    exp_q.push_back({1'b0, 8'h55, 8'h00});
    frame(OP_READ, 8'h55, 24'h000000, 26, -1, 20);
    check("xrst_in_txsh", st_tr[20], TXSH);
    check("xrst_vec", trace[21], V_IDLE);
    check("xrst_state", st_tr[21], IDLE);
    check("xrst_busy", busy_tr[21], 0);
    check("xrst_cnt_cleared", cnt_tr[22], 0);
    check("xrst_resume_cmd", trace[23], V_CMD);
    check("xrst_re_count", count_bit(11, 0, 25), 1);
    check("xrst_shift_count", count_bit(8, 17, 25), 3);
    check("xrst_sb_drained", exp_q.size(), 0);

`ifdef SPI_SEQ_BURST_EN
    // Burst write of 3 bytes from 0xFE; third byte lands at 0x00.
    exp_q.push_back({1'b1, 8'hFE, 8'h11});
    exp_q.push_back({1'b1, 8'hFF, 8'h22});
    exp_q.push_back({1'b1, 8'h00, 8'h33});
    frame(OP_WRITE, 8'hFE, 24'h112233, 43, -1, -1);
    check("burst_we_count", count_bit(12, 0, 42), 3);
    check("burst_inc_count", count_bit(13, 0, 42), 3);
    check("burst_addr_wrap", addr_m, 8'h01);
    check("burst_sb_drained", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
